// File: rtl/jcontrol.sv
// Control sequencer for a simple 8-bit CPU: steps 1..7, four clock phases per step,
// and per-step bus-enable and set strobes decoded from the instruction register.
module jcontrol (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [0:7] ir,
  output logic [0:6] step,
  output logic       clke,
  output logic       clks,
  output logic       bus1,
  output logic       e_iar,
  output logic       e_ram,
  output logic       e_acc,
  output logic [0:3] e_reg,
  output logic       s_iar,
  output logic       s_mar,
  output logic       s_acc,
  output logic       s_ram,
  output logic       s_tmp,
  output logic       s_ir,
  output logic [0:3] s_reg,
  output logic [0:2] alu_op
);

  typedef enum logic [2:0] {
    IDLE, STEP1, STEP2, STEP3, STEP4, STEP5, STEP6, STEP7
  } stateT;

  stateT      state, stateNext;
  logic [1:0] phase, phaseNext;

  logic       isAlu, isLd, isSt, isData, isCmp;
  logic [1:0] ra, rb;
  logic       active;

  logic       wBus1, wIar, wRam, wAcc, wRegOn;
  logic [1:0] wRegIdx;
  logic       wsIar, wsMar, wsAcc, wsRam, wsTmp, wsIr, wsRegOn;
  logic [1:0] wsRegIdx;

  assign isAlu  = ir[0];
  assign isLd   = (ir[0:3] == 4'b0000);
  assign isSt   = (ir[0:3] == 4'b0001);
  assign isData = (ir[0:3] == 4'b0010);
  assign isCmp  = (ir[1:3] == 3'b111);
  assign ra     = ir[4:5];
  assign rb     = ir[6:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 2'd0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
    end
  end

  // Steps 1..6 run four phases each; step 7 is a single cycle that samples run.
  always_comb begin
    stateNext = state;
    phaseNext = 2'd0;
    case (state)
      IDLE:    if (run) stateNext = STEP1;
      STEP7:   stateNext = run ? STEP1 : IDLE;
      default: begin
        phaseNext = phase + 2'd1;
        if (phase == 2'd3) stateNext = stateT'(state + 3'd1);
      end
    endcase
  end

  assign active = (state != IDLE) && (state != STEP7);
  assign clke   = active && (phase != 2'd3);
  assign clks   = active && (phase == 2'd1);

  always_comb begin
    step     = 7'b0000000;
    alu_op   = 3'b000;
    wBus1    = 1'b0;
    wIar     = 1'b0;
    wRam     = 1'b0;
    wAcc     = 1'b0;
    wRegOn   = 1'b0;
    wRegIdx  = 2'd0;
    wsIar    = 1'b0;
    wsMar    = 1'b0;
    wsAcc    = 1'b0;
    wsRam    = 1'b0;
    wsTmp    = 1'b0;
    wsIr     = 1'b0;
    wsRegOn  = 1'b0;
    wsRegIdx = 2'd0;
    case (state)
      STEP1: begin
        step  = 7'b1000000;
        wBus1 = 1'b1;
        wIar  = 1'b1;
        wsMar = 1'b1;
        wsAcc = 1'b1;
      end
      STEP2: begin
        step = 7'b0100000;
        wRam = 1'b1;
        wsIr = 1'b1;
      end
      STEP3: begin
        step  = 7'b0010000;
        wAcc  = 1'b1;
        wsIar = 1'b1;
      end
      STEP4: begin
        step = 7'b0001000;
        if (isAlu) begin
          wRegOn  = 1'b1;
          wRegIdx = rb;
          wsTmp   = 1'b1;
        end else if (isLd || isSt) begin
          wRegOn  = 1'b1;
          wRegIdx = ra;
          wsMar   = 1'b1;
        end else if (isData) begin
          wBus1 = 1'b1;
          wIar  = 1'b1;
          wsMar = 1'b1;
          wsAcc = 1'b1;
        end
      end
      STEP5: begin
        step = 7'b0000100;
        if (isAlu) begin
          alu_op  = ir[1:3];
          wRegOn  = 1'b1;
          wRegIdx = ra;
          wsAcc   = 1'b1;
        end else if (isLd || isData) begin
          wRam     = 1'b1;
          wsRegOn  = 1'b1;
          wsRegIdx = rb;
        end else if (isSt) begin
          wRegOn  = 1'b1;
          wRegIdx = rb;
          wsRam   = 1'b1;
        end
      end
      STEP6: begin
        step = 7'b0000010;
        if (isAlu && !isCmp) begin
          wAcc     = 1'b1;
          wsRegOn  = 1'b1;
          wsRegIdx = rb;
        end else if (isData) begin
          wAcc  = 1'b1;
          wsIar = 1'b1;
        end
      end
      STEP7:   step = 7'b0000001;
      default: step = 7'b0000000;
    endcase
  end

  // Enables follow clke, sets follow clks; the register selects stay one-hot.
  assign bus1  = wBus1 && clke;
  assign e_iar = wIar && clke;
  assign e_ram = wRam && clke;
  assign e_acc = wAcc && clke;
  assign e_reg = (wRegOn && clke) ? (4'b1000 >> wRegIdx) : 4'b0000;
  assign s_iar = wsIar && clks;
  assign s_mar = wsMar && clks;
  assign s_acc = wsAcc && clks;
  assign s_ram = wsRam && clks;
  assign s_tmp = wsTmp && clks;
  assign s_ir  = wsIr && clks;
  assign s_reg = (wsRegOn && clks) ? (4'b1000 >> wsRegIdx) : 4'b0000;

endmodule

// File: tb/tb_jcontrol.sv
// Directed bench for jcontrol: walks ADD, CMP, DATA, LD, ST and an undefined opcode
// through full instructions, plus reset and run-gating scenarios.
module tb_jcontrol;

  logic       clk;
  logic       rst;
  logic       run;
  logic [0:7] ir;
  logic [0:6] step;
  logic       clke, clks;
  logic       bus1, e_iar, e_ram, e_acc;
  logic [0:3] e_reg;
  logic       s_iar, s_mar, s_acc, s_ram, s_tmp, s_ir;
  logic [0:3] s_reg;
  logic [0:2] alu_op;

  logic [9:0] sets;
  logic [7:0] ens;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;
  bit expRun = 1'b0;

  jcontrol dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .ir    (ir),
    .step  (step),
    .clke  (clke),
    .clks  (clks),
    .bus1  (bus1),
    .e_iar (e_iar),
    .e_ram (e_ram),
    .e_acc (e_acc),
    .e_reg (e_reg),
    .s_iar (s_iar),
    .s_mar (s_mar),
    .s_acc (s_acc),
    .s_ram (s_ram),
    .s_tmp (s_tmp),
    .s_ir  (s_ir),
    .s_reg (s_reg),
    .alu_op(alu_op)
  );

  assign sets = {s_iar, s_mar, s_acc, s_ram, s_tmp, s_ir, s_reg};
  assign ens  = {bus1, e_iar, e_ram, e_acc, e_reg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic [0:7] i);
    rst = r;
    run = rn;
    ir  = i;
  endtask

  // One clock, then the invariants that must hold in every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("stepOneHot", $countones(step), expRun ? 32'd1 : 32'd0);
    checkOutput("setWithoutClks", {31'd0, (!clks && sets != 10'd0)}, 32'd0);
    checkOutput("enableWithoutClke", {31'd0, (!clke && ens != 8'd0)}, 32'd0);
  endtask

  task automatic goTo(input int rel);
    while (cyc - base < rel) tick();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".step"}, step, 7'b0000000);
    checkOutput({tag, ".alu_op"}, alu_op, 3'b000);
    checkOutput({tag, ".ens"}, ens, 8'd0);
    checkOutput({tag, ".sets"}, sets, 10'd0);
    checkOutput({tag, ".clke"}, clke, 1'b0);
    checkOutput({tag, ".clks"}, clks, 1'b0);
  endtask

  initial begin
    // Reset with run already high: reset must win.
    applyStimulus(1'b1, 1'b1, 8'b10000110);
    tick();
    checkIdle("reset1");
    tick();
    checkIdle("reset2");

    // ADD R1,R2
    applyStimulus(1'b0, 1'b1, 8'b10000110);
    base = cyc;
    expRun = 1'b1;
    goTo(1);
    checkOutput("add.c1.step", step, 7'b1000000);
    checkOutput("add.c1.clke", clke, 1'b1);
    checkOutput("add.c1.clks", clks, 1'b0);
    checkOutput("add.c1.bus1", bus1, 1'b1);
    checkOutput("add.c1.e_iar", e_iar, 1'b1);
    checkOutput("add.c1.s_mar", s_mar, 1'b0);
    checkOutput("add.c1.s_acc", s_acc, 1'b0);
    goTo(2);
    checkOutput("add.c2.s_mar", s_mar, 1'b1);
    checkOutput("add.c2.s_acc", s_acc, 1'b1);
    checkOutput("add.c2.clks", clks, 1'b1);
    goTo(5);
    checkOutput("add.c5.step", step, 7'b0100000);
    checkOutput("add.c5.e_ram", e_ram, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'b11111111);
    goTo(6);
    checkOutput("irIgnored.c6.s_ir", s_ir, 1'b1);
    checkOutput("irIgnored.c6.e_reg", e_reg, 4'b0000);
    checkOutput("irIgnored.c6.s_reg", s_reg, 4'b0000);
    checkOutput("irIgnored.c6.alu_op", alu_op, 3'b000);
    goTo(9);
    checkOutput("add.c9.step", step, 7'b0010000);
    checkOutput("add.c9.e_acc", e_acc, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'b10000110);
    goTo(10);
    checkOutput("add.c10.s_iar", s_iar, 1'b1);
    goTo(13);
    checkOutput("add.c13.step", step, 7'b0001000);
    checkOutput("add.c13.e_reg", e_reg, 4'b0010);
    checkOutput("add.c13.s_tmp", s_tmp, 1'b0);
    goTo(14);
    checkOutput("add.c14.s_tmp", s_tmp, 1'b1);
    goTo(16);
    checkOutput("add.c16.clke", clke, 1'b0);
    checkOutput("add.c16.e_reg", e_reg, 4'b0000);
    goTo(17);
    checkOutput("add.c17.e_reg", e_reg, 4'b0100);
    checkOutput("add.c17.s_acc", s_acc, 1'b0);
    checkOutput("add.c17.alu_op", alu_op, 3'b000);
    goTo(18);
    checkOutput("add.c18.s_acc", s_acc, 1'b1);
    checkOutput("add.c18.alu_op", alu_op, 3'b000);
    goTo(22);
    checkOutput("add.c22.e_acc", e_acc, 1'b1);
    checkOutput("add.c22.s_reg", s_reg, 4'b0010);
    goTo(25);
    checkOutput("add.c25.step", step, 7'b0000001);
    checkOutput("add.c25.sets", sets, 10'd0);
    checkOutput("add.c25.ens", ens, 8'd0);
    checkOutput("add.c25.clke", clke, 1'b0);

    // CMP R1,R2: alu_op 111 for all of step 5, nothing in step 6
    applyStimulus(1'b0, 1'b1, 8'b11110110);
    base = base + 25;
    goTo(1);
    checkOutput("cmp.c1.step", step, 7'b1000000);
    goTo(17);
    checkOutput("cmp.c17.alu_op", alu_op, 3'b111);
    checkOutput("cmp.c17.e_reg", e_reg, 4'b0100);
    goTo(18);
    checkOutput("cmp.c18.alu_op", alu_op, 3'b111);
    checkOutput("cmp.c18.s_acc", s_acc, 1'b1);
    goTo(20);
    checkOutput("cmp.c20.alu_op", alu_op, 3'b111);
    goTo(21);
    checkOutput("cmp.c21.ens", ens, 8'd0);
    checkOutput("cmp.c21.alu_op", alu_op, 3'b000);
    goTo(22);
    checkOutput("cmp.c22.sets", sets, 10'd0);
    goTo(25);
    checkOutput("cmp.c25.step", step, 7'b0000001);

    // DATA R3, with run briefly dropped during step 3
    base = base + 25;
    goTo(1);
    checkOutput("data.c1.step", step, 7'b1000000);
    applyStimulus(1'b0, 1'b1, 8'b00100011);
    goTo(9);
    applyStimulus(1'b0, 1'b0, 8'b00100011);
    goTo(11);
    applyStimulus(1'b0, 1'b1, 8'b00100011);
    goTo(13);
    checkOutput("data.c13.bus1", bus1, 1'b1);
    checkOutput("data.c13.e_iar", e_iar, 1'b1);
    checkOutput("data.c13.e_reg", e_reg, 4'b0000);
    goTo(14);
    checkOutput("data.c14.s_mar", s_mar, 1'b1);
    checkOutput("data.c14.s_acc", s_acc, 1'b1);
    goTo(17);
    checkOutput("data.c17.e_ram", e_ram, 1'b1);
    goTo(18);
    checkOutput("data.c18.s_reg", s_reg, 4'b0001);
    goTo(21);
    checkOutput("data.c21.e_acc", e_acc, 1'b1);
    goTo(22);
    checkOutput("data.c22.s_iar", s_iar, 1'b1);
    checkOutput("data.c22.s_reg", s_reg, 4'b0000);
    goTo(25);
    checkOutput("data.c25.step", step, 7'b0000001);

    // LD R1->R2, run dropped in step 3 and held low through step 7
    base = base + 25;
    goTo(1);
    checkOutput("ld.c1.step", step, 7'b1000000);
    applyStimulus(1'b0, 1'b1, 8'b00000110);
    goTo(9);
    applyStimulus(1'b0, 1'b0, 8'b00000110);
    goTo(13);
    checkOutput("ld.c13.e_reg", e_reg, 4'b0100);
    goTo(14);
    checkOutput("ld.c14.s_mar", s_mar, 1'b1);
    goTo(17);
    checkOutput("ld.c17.e_ram", e_ram, 1'b1);
    goTo(18);
    checkOutput("ld.c18.s_reg", s_reg, 4'b0010);
    goTo(22);
    checkOutput("ld.c22.sets", sets, 10'd0);
    checkOutput("ld.c22.ens", ens, 8'd0);
    goTo(25);
    checkOutput("ld.c25.step", step, 7'b0000001);
    expRun = 1'b0;
    goTo(26);
    checkIdle("idleAfterStop");
    goTo(27);
    checkOutput("idleHold.step", step, 7'b0000000);

    // ST R1,R2, then reset in step 5 phase 1
    applyStimulus(1'b0, 1'b1, 8'b00010110);
    base = base + 27;
    expRun = 1'b1;
    goTo(1);
    checkOutput("st.c1.step", step, 7'b1000000);
    goTo(13);
    checkOutput("st.c13.e_reg", e_reg, 4'b0100);
    goTo(14);
    checkOutput("st.c14.s_mar", s_mar, 1'b1);
    goTo(17);
    checkOutput("st.c17.e_reg", e_reg, 4'b0010);
    goTo(18);
    checkOutput("st.c18.s_ram", s_ram, 1'b1);
    checkOutput("st.c18.s_reg", s_reg, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'b00010110);
    expRun = 1'b0;
    tick();
    checkIdle("midReset");
    tick();
    checkOutput("midResetHold.step", step, 7'b0000000);

    // Undefined opcode: fetch only, steps 4..6 silent
    applyStimulus(1'b0, 1'b1, 8'b00111111);
    base = cyc;
    expRun = 1'b1;
    goTo(1);
    checkOutput("undef.c1.step", step, 7'b1000000);
    goTo(14);
    checkOutput("undef.c14.sets", sets, 10'd0);
    checkOutput("undef.c14.ens", ens, 8'd0);
    goTo(17);
    checkOutput("undef.c17.ens", ens, 8'd0);
    checkOutput("undef.c17.alu_op", alu_op, 3'b000);
    goTo(22);
    checkOutput("undef.c22.sets", sets, 10'd0);
    goTo(25);
    checkOutput("undef.c25.step", step, 7'b0000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
